mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle CPU control unit.
- Sits directly upstream of the 32-bit load-enable registers (PC, IR, MDR, A/B, ALUOut) and drives their Load inputs and the datapath mux selects.
- Sequences the MIPS subset R-type/lw/sw/beq/j/addi through a Moore FSM with a memory-ready handshake.
- Exposes state and an illegal-opcode pulse for debug.

Parameters:
- WAIT_EN, 1: 1 = IF/MR/MW stall until mem_ready; 0 = mem_ready ignored (treated as 1).
- STATE_W, 4: width of state encoding and of state_o.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous, active-high reset; one clock; polarity and synchronicity fixed.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes access this cycle.
- PCWrite  out  1  PC register Load.
- PCWriteCond  out  1  PC Load if zero.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR Load.
- MemtoReg  out  1  regfile write data from MDR.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  regfile write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct, 11 add (addi).
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- illegal  out  1  one-cycle pulse on undecoded opcode.
- state_o  out  STATE_W  current state.

Behaviour:
- Encoding: IF=0, ID=1, MADR=2, MRD=3, LWB=4, MWR=5, REX=6, RWB=7, BEQ=8, JMP=9, IEX=10, IWB=11.
- Codes 12-15 are unreachable; if entered, next state = IF.
- Clear at a rising edge forces state = IF. This holds mid-instruction, mid-stall and regardless of mem_ready; no partial writes are completed.
- Outputs are combinational decodes of state, plus mem_ready gating. Every output not listed for a state is 0.
- After clear: state_o=0, MemRead=1, ALUSrcB=01, PCWrite=IRWrite=mem_ready, all others 0, illegal=0.
- IF:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Go to ID when mem_ready, else stay in IF.
  - PC and IR load exactly once per fetch.
- ID:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: 000000→REX, 100011/101011→MADR, 000100→BEQ, 000010→JMP, 001000→IEX, other→IF with illegal=1 this cycle.
- MADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw→MRD, sw→MWR.
- MRD: MemRead=1, IorD=1. Stay until mem_ready, then →LWB.
- LWB: RegWrite=1, MemtoReg=1, RegDst=0. Next →IF.
- MWR: MemWrite=1, IorD=1. Stay until mem_ready, then →IF. MemWrite is held high throughout the stall.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next →RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next →IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next →IF. Effective PC load = PCWriteCond & zero.
- JMP: PCWrite=1, PCSource=10. Next →IF.
- IEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next →IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next →IF.
- Cycles per instruction with no stalls: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- opcode is sampled only in ID and MADR, so IR changes elsewhere have no effect.
- WAIT_EN=0: the mem_ready input is ignored and treated as 1 internally everywhere, including the IF gating of PCWrite/IRWrite. lw=5 and sw=4 cycles fixed.
- PCWrite and MemWrite are never both 1 in the same cycle. RegWrite is asserted at most once per instruction.

Test Plan:
- Clear asserted 2 cycles in MRD with mem_ready=1 → next state_o=0, RegWrite never pulses. Post-clear IF with mem_ready=0 shows MemRead=1, PCWrite=0.
- R-type (opcode 000000), mem_ready tied 1 → state_o 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4. IRWrite=1 only in cycle 1.
- lw (100011), mem_ready low 3 cycles in MRD → states 0,1,2,3,3,3,3,4,0. IorD=1 through the stall. MemtoReg=RegWrite=1 in LWB.
- sw (101011) with IF stalled 2 cycles → IRWrite=PCWrite=1 exactly once, on the ready cycle. MemWrite held high in MWR until mem_ready, then →IF.
- beq (000100), zero=1 then repeat with zero=0 → 3 cycles each. PCWriteCond=1, PCSource=01 in state 8 both times; the PC load occurs only with zero=1.
- Opcode 111111 → ID then IF, illegal=1 for exactly one cycle. Then j (000010) → state 9 with PCWrite=1, PCSource=10.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit (R-type/lw/sw/beq/j/addi).
// Moore FSM; datapath controls are decoded from the current state, with
// memory-ready gating on the fetch loads and the memory-stall states.
module mc_ctrl_fsm #(
  parameter int unsigned WAIT_EN = 1,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] S_IF   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_ID   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_LWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_REX  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_RWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQ  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JMP  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IEX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_IWB  = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               ready;

  // With waiting disabled the memory is assumed to complete every access.
  assign ready   = (WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state_o = state_q;

  // Next-state selection; unreachable codes fall back to fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (ready) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_RTYPE:    state_d = S_REX;
          OP_LW, OP_SW: state_d = S_MADR;
          OP_BEQ:      state_d = S_BEQ;
          OP_J:        state_d = S_JMP;
          OP_ADDI:     state_d = S_IEX;
          default:     state_d = S_IF;
        endcase
      end
      S_MADR: begin
        if (opcode == OP_LW)      state_d = S_MRD;
        else if (opcode == OP_SW) state_d = S_MWR;
        else                      state_d = S_IF;
      end
      S_MRD:  if (ready) state_d = S_LWB;
      S_LWB:  state_d = S_IF;
      S_MWR:  if (ready) state_d = S_IF;
      S_REX:  state_d = S_RWB;
      S_RWB:  state_d = S_IF;
      S_BEQ:  state_d = S_IF;
      S_JMP:  state_d = S_IF;
      S_IEX:  state_d = S_IWB;
      S_IWB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // State register; clear abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (clear) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Datapath control decode; anything not set for a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC and IR load only on the completing fetch cycle.
        IRWrite = ready;
        PCWrite = ready;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        illegal = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      S_MADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed instruction sequences followed
// by randomized opcode/ready/clear traffic, all checked against a model that
// expands each decoded instruction into its list of remaining states.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       clear, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;
  logic [16:0] act_outs;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: expected state plus queue of states still to visit this instruction.
  int m_state = 0;
  int m_q[$];
  int rw_cnt = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.WAIT_EN(1), .STATE_W(4)) dut (
    .clk        (clk),
    .clear      (clear),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  assign act_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J ||
           op == OP_ADDI;
  endfunction

  // Control table: packed in the same order as act_outs.
  function automatic logic [16:0] exp_outs(input int st, input logic rdy, input logic [5:0] op);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin srcb = 2'b11; ill = !is_legal(op); end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
  endfunction

  function automatic int pop_next();
    return (m_q.size() > 0) ? m_q.pop_front() : 0;
  endfunction

  // One clock: drive inputs at the falling edge, check, then advance the model.
  task automatic step(input logic clr, input logic rdy, input logic [5:0] op, input logic z);
    clear = clr; mem_ready = rdy; opcode = op; zero = z;
    #1;
    check_eq("state", 32'(state_o), m_state);
    check_eq("outs", 32'(act_outs), 32'(exp_outs(m_state, rdy, op)));
    check_eq("pc_load", 32'(PCWrite | (PCWriteCond & zero)),
             32'((m_state == 0 && rdy) || m_state == 9 || (m_state == 8 && z)));
    check_eq("pcw_and_memw", 32'(PCWrite & MemWrite), 0);
    if (RegWrite) rw_cnt++;
    @(posedge clk);
    if (clr) begin
      m_state = 0;
      m_q.delete();
      rw_cnt = 0;
    end else begin
      case (m_state)
        0: if (rdy) begin
          check_eq("regwrite_once", 32'(rw_cnt <= 1), 1);
          rw_cnt  = 0;
          m_state = 1;
        end
        1: begin
          m_q.delete();
          case (op)
            OP_R:    m_q = '{6, 7};
            OP_LW:   m_q = '{2, 3, 4};
            OP_SW:   m_q = '{2, 5};
            OP_BEQ:  m_q = '{8};
            OP_J:    m_q = '{9};
            OP_ADDI: m_q = '{10, 11};
            default: ;
          endcase
          m_state = pop_next();
        end
        3, 5: if (rdy) m_state = pop_next();
        default: m_state = pop_next();
      endcase
    end
    @(negedge clk);
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    if ($urandom_range(0, 4) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    logic [5:0] op;
    clear = 1'b1; mem_ready = 1'b0; opcode = OP_R; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Post-reset fetch stalled: MemRead high, no PC/IR load.
    step(0, 0, OP_R, 0);

    // R-type, no stalls: 0,1,6,7,0.
    step(0, 1, OP_R, 0);
    step(0, 1, OP_R, 0);
    step(0, 1, OP_R, 0);
    step(0, 1, OP_R, 0);

    // lw with three wait cycles in MRD.
    step(0, 1, OP_LW, 0);
    step(0, 1, OP_LW, 0);
    step(0, 1, OP_LW, 0);
    repeat (3) step(0, 0, OP_LW, 0);
    step(0, 1, OP_LW, 0);
    step(0, 1, OP_LW, 0);

    // Clear while in MRD with memory ready: LWB never reached.
    step(0, 1, OP_LW, 0);
    step(0, 1, OP_LW, 0);
    step(0, 1, OP_LW, 0);
    step(1, 1, OP_LW, 0);
    step(1, 1, OP_LW, 0);
    step(0, 0, OP_LW, 0);

    // sw with IF stalled twice and MWR stalled twice.
    step(0, 0, OP_SW, 0);
    step(0, 0, OP_SW, 0);
    step(0, 1, OP_SW, 0);
    step(0, 1, OP_SW, 0);
    step(0, 1, OP_SW, 0);
    step(0, 0, OP_SW, 0);
    step(0, 0, OP_SW, 0);
    step(0, 1, OP_SW, 0);

    // beq taken then not taken.
    for (int z = 1; z >= 0; z--) begin
      step(0, 1, OP_BEQ, 1'(z));
      step(0, 1, OP_BEQ, 1'(z));
      step(0, 1, OP_BEQ, 1'(z));
    end

    // Illegal opcode, then a jump.
    step(0, 1, OP_BAD, 0);
    step(0, 1, OP_BAD, 0);
    step(0, 1, OP_J, 0);
    step(0, 1, OP_J, 0);
    step(0, 1, OP_J, 0);

    // addi.
    repeat (4) step(0, 1, OP_ADDI, 0);

    // Random traffic; opcode held through MADR so lw/sw routing stays defined.
    op = OP_R;
    for (int i = 0; i < 4000; i++) begin
      if (m_state != 2) op = rand_op();
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), op, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
